// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI register bank: decode FSM state encoding,
// address field positions of the upstream 6-bit address, the default
// commit/abort command address and the data bit that selects commit vs abort.
// -----------------------------------------------------------------------------
package spi_reg_pkg;

  // Two-state decode FSM: wait for a strobe, then spend one cycle acting on it.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DECODE = 1'b1
  } state_t;

  // Upstream address layout: bit 5 flags a read, bits 4:0 are the register.
  localparam int READ_BIT = 5;
  localparam int ADDR_MSB = 4;

  // Command address that commits (data bit set) or aborts (data bit clear).
  localparam logic [4:0] DEFAULT_COMMIT_ADDR = 5'd31;

  // Data bit inspected on a command write: 1 = commit, 0 = abort.
  localparam int CMD_BIT = 0;

endpackage

// File: rtl/spi_strobe_sync.sv
// -----------------------------------------------------------------------------
// spi_strobe_sync
// Brings the SCK-domain write strobe into the system clock domain through a
// two-flop synchronizer and produces a single-cycle pulse on its rising edge.
//
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous active-high reset
//   i_strobe       raw strobe from the SCK domain
//   o_strobe_rise  one-cycle pulse, high in the cycle after the second
//                  synchronizer stage first sees the strobe
// -----------------------------------------------------------------------------
module spi_strobe_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_strobe,
  output logic o_strobe_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_strobe;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Decoded purely from flops, so there is no combinational path from i_strobe.
  assign o_strobe_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// Double-buffered control register bank fed by an SPI serial-register slave.
// Each completed SPI write is synchronized into the system clock domain and
// decoded: register writes land in the shadow bank, a command write to
// COMMIT_ADDR either copies shadow -> active (commit) or active -> shadow
// (abort), reads are ignored, and anything else bumps a saturating counter.
//
// Ports:
//   i_clock          system clock (>= 4x SCK)
//   i_reset          asynchronous active-high reset
//   i_saddr          upstream address; bit 5 = read flag, bits 4:0 = register
//   i_sdata          upstream write data
//   i_sstrobe        upstream write strobe (SCK domain, one SCK period)
//   o_regs           active bank, register n at [n*WIDTH +: WIDTH]
//   o_shadow_rd      shadow bank, same packing, for SPI readback
//   o_wr_pulse       one-cycle pulse on bit n when shadow register n is written
//   o_commit_pulse   one-cycle pulse when shadow is copied to active
//   o_bad_addr_cnt   saturating count of writes to unmapped addresses
//   o_busy           high while the decode FSM is out of IDLE
// -----------------------------------------------------------------------------
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_REGS    = 3,
  parameter logic [4:0]       COMMIT_ADDR = DEFAULT_COMMIT_ADDR,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [5:0]                i_saddr,
  input  logic [WIDTH-1:0]          i_sdata,
  input  logic                      i_sstrobe,
  output logic [NUM_REGS*WIDTH-1:0] o_regs,
  output logic [NUM_REGS*WIDTH-1:0] o_shadow_rd,
  output logic [NUM_REGS-1:0]       o_wr_pulse,
  output logic                      o_commit_pulse,
  output logic [7:0]                o_bad_addr_cnt,
  output logic                      o_busy
);

  localparam logic [4:0] LP_NUM_REGS = 5'(NUM_REGS);

  logic             w_strobe_rise;
  state_t           r_state;
  logic             r_busy;
  logic [5:0]       r_cap_addr;
  logic [WIDTH-1:0] r_cap_data;
  logic             r_commit_pulse;
  logic [7:0]       r_bad_addr_cnt;

  logic       w_decode;
  logic       w_is_read;
  logic [4:0] w_addr;
  logic       w_is_cmd;
  logic       w_in_range;
  logic       w_commit;
  logic       w_abort;
  logic       w_wr_en;
  logic       w_bad;

  spi_strobe_sync u_sync (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_strobe      (i_sstrobe),
    .o_strobe_rise (w_strobe_rise)
  );

  // Decode FSM. The address and data are captured only in the strobe_rise
  // cycle; a strobe_rise arriving during DECODE is dropped.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strobe_rise) begin
            r_cap_addr <= i_saddr;
            r_cap_data <= i_sdata;
            r_state    <= ST_DECODE;
            r_busy     <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Action selects, only meaningful in the DECODE cycle. Read commands take
  // priority and suppress every other action.
  assign w_decode   = (r_state == ST_DECODE);
  assign w_is_read  = r_cap_addr[READ_BIT];
  assign w_addr     = r_cap_addr[ADDR_MSB:0];
  assign w_is_cmd   = (w_addr == COMMIT_ADDR);
  assign w_in_range = (w_addr < LP_NUM_REGS);
  assign w_commit   = w_decode & ~w_is_read &  w_is_cmd &  r_cap_data[CMD_BIT];
  assign w_abort    = w_decode & ~w_is_read &  w_is_cmd & ~r_cap_data[CMD_BIT];
  assign w_wr_en    = w_decode & ~w_is_read & ~w_is_cmd &  w_in_range;
  assign w_bad      = w_decode & ~w_is_read & ~w_is_cmd & ~w_in_range;

  // One shadow/active pair per register. Commit and abort touch every
  // register on the same edge, which is what makes the transfer atomic.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic             w_sel;
      logic [WIDTH-1:0] r_shadow;
      logic [WIDTH-1:0] r_active;
      logic             r_wr_pulse;

      assign w_sel = w_wr_en & (w_addr == 5'(gi));

      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_shadow   <= RESET_VALUE;
          r_active   <= RESET_VALUE;
          r_wr_pulse <= 1'b0;
        end else begin
          r_wr_pulse <= w_sel;
          if (w_sel) begin
            r_shadow <= r_cap_data;
          end else if (w_abort) begin
            r_shadow <= r_active;
          end
          if (w_commit) begin
            r_active <= r_shadow;
          end
        end
      end

      assign o_regs[gi*WIDTH +: WIDTH]      = r_active;
      assign o_shadow_rd[gi*WIDTH +: WIDTH] = r_shadow;
      assign o_wr_pulse[gi]                 = r_wr_pulse;
    end
  endgenerate

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_commit_pulse <= 1'b0;
      r_bad_addr_cnt <= 8'd0;
    end else begin
      r_commit_pulse <= w_commit;
      if (w_bad && (r_bad_addr_cnt != 8'hFF)) begin
        r_bad_addr_cnt <= r_bad_addr_cnt + 8'd1;
      end
    end
  end

  assign o_commit_pulse = r_commit_pulse;
  assign o_bad_addr_cnt = r_bad_addr_cnt;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

  logic        clk;
  logic        reset;
  logic [5:0]  saddr;
  logic [7:0]  sdata;
  logic        sstrobe;
  logic [23:0] regs;
  logic [23:0] shadow_rd;
  logic [2:0]  wr_pulse;
  logic        commit_pulse;
  logic [7:0]  bad_addr_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  wr;
    logic        commit;
    logic [23:0] regs;
    logic [23:0] shadow;
    logic [7:0]  bad;
  } exp_t;

  exp_t exp_q[$];

  spi_reg_bank #(
    .WIDTH       (8),
    .NUM_REGS    (3),
    .COMMIT_ADDR (5'd31),
    .RESET_VALUE (8'h00)
  ) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_saddr        (saddr),
    .i_sdata        (sdata),
    .i_sstrobe      (sstrobe),
    .o_regs         (regs),
    .o_shadow_rd    (shadow_rd),
    .o_wr_pulse     (wr_pulse),
    .o_commit_pulse (commit_pulse),
    .o_bad_addr_cnt (bad_addr_cnt),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] wr, input logic c, input logic [23:0] rg,
                      input logic [23:0] sh, input logic [7:0] bd);
    exp_t e;
    e.wr = wr; e.commit = c; e.regs = rg; e.shadow = sh; e.bad = bd;
    exp_q.push_back(e);
  endtask

  task automatic do_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got output event expected none", tag);
    end else begin
      e = exp_q.pop_front();
      $display("[%0t] %s wr=%b commit=%b regs=%06h shadow=%06h bad=%0d busy=%b",
               $time, tag, wr_pulse, commit_pulse, regs, shadow_rd, bad_addr_cnt, busy);
      chk({tag, "_wr_pulse"},     32'(wr_pulse),     32'(e.wr));
      chk({tag, "_commit_pulse"}, 32'(commit_pulse), 32'(e.commit));
      chk({tag, "_regs"},         32'(regs),         32'(e.regs));
      chk({tag, "_shadow_rd"},    32'(shadow_rd),    32'(e.shadow));
      chk({tag, "_bad_addr_cnt"}, 32'(bad_addr_cnt), 32'(e.bad));
      chk({tag, "_busy"},         32'(busy),         32'd0);
    end
  endtask

  // Monitor: an output event is either the first cycle of reset or the cycle
  // right after DECODE (busy falling), where the pulses are visible. In every
  // other cycle out of reset the pulses must be low.
  initial begin
    logic busy_prev;
    logic rst_prev;
    busy_prev = 1'b0;
    rst_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && !rst_prev) begin
        do_pop("rst");
      end else if (!reset && busy_prev && !busy) begin
        do_pop("txn");
      end else if (!reset) begin
        chk("idle_pulses", 32'({wr_pulse, commit_pulse}), 32'd0);
      end
      busy_prev = busy;
      rst_prev  = reset;
    end
  end

  // One SPI write: strobe held one SCK period (~12 clocks), then a gap.
  task automatic send(input logic [5:0] a, input logic [7:0] d,
                      input logic [2:0] wr, input logic c, input logic [23:0] rg,
                      input logic [23:0] sh, input logic [7:0] bd);
    int lat;
    push(wr, c, rg, sh, bd);
    @(posedge clk); #1;
    saddr   = a;
    sdata   = d;
    sstrobe = 1'b1;
    lat = 0;
    while (!busy && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("strobe_to_busy_latency", 32'(lat), 32'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    sstrobe = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    int wait_cnt;
    saddr   = 6'd0;
    sdata   = 8'd0;
    sstrobe = 1'b0;
    push(3'b000, 1'b0, 24'h000000, 24'h000000, 8'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    send(6'h01, 8'hA5, 3'b010, 1'b0, 24'h000000, 24'h00A500, 8'd0);
    send(6'h1F, 8'h01, 3'b000, 1'b1, 24'h00A500, 24'h00A500, 8'd0);
    send(6'h00, 8'h3C, 3'b001, 1'b0, 24'h00A500, 24'h00A53C, 8'd0);
    send(6'h1F, 8'h00, 3'b000, 1'b0, 24'h00A500, 24'h00A500, 8'd0);
    send(6'h21, 8'h77, 3'b000, 1'b0, 24'h00A500, 24'h00A500, 8'd0);
    send(6'h05, 8'h12, 3'b000, 1'b0, 24'h00A500, 24'h00A500, 8'd1);
    send(6'h02, 8'h5A, 3'b100, 1'b0, 24'h00A500, 24'h5AA500, 8'd1);
    send(6'h1F, 8'hFF, 3'b000, 1'b1, 24'h5AA500, 24'h5AA500, 8'd1);
    send(6'h03, 8'h11, 3'b000, 1'b0, 24'h5AA500, 24'h5AA500, 8'd2);
    send(6'h1E, 8'h22, 3'b000, 1'b0, 24'h5AA500, 24'h5AA500, 8'd3);
    send(6'h3F, 8'h01, 3'b000, 1'b0, 24'h5AA500, 24'h5AA500, 8'd3);

    // 298 more unmapped writes: 301 in total, counter pinned at 255.
    for (int i = 0; i < 298; i++) begin
      send(6'h05, 8'(i), 3'b000, 1'b0, 24'h5AA500, 24'h5AA500,
           (4 + i > 255) ? 8'd255 : 8'(4 + i));
    end

    // Reg2 write interrupted by reset during DECODE.
    push(3'b000, 1'b0, 24'h000000, 24'h000000, 8'd0);
    @(posedge clk); #1;
    saddr   = 6'h02;
    sdata   = 8'h99;
    sstrobe = 1'b1;
    lat = 0;
    while (!busy && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("reset_case_busy_latency", 32'(lat), 32'd3);
    reset   = 1'b1;
    sstrobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // A read command afterwards snapshots the bank: reg2 must not be written.
    send(6'h22, 8'h33, 3'b000, 1'b0, 24'h000000, 24'h000000, 8'd0);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
